// File: rtl/i2s_pkg.sv
// Shared types and constants for the SGTL5000 I2S receive path.
package i2s_pkg;

    localparam int I2S_DATA_W_DEFAULT = 16;
    localparam int SLOTS_PER_FRAME    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-stage synchronizer for one codec pin with registered edge detect.
// level is delayed to line up with rise/fall, so sibling instances stay aligned.
module i2s_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              last_r;
    logic              rise_r;
    logic              fall_r;

    // synchronizer chain plus one-cycle-old copy for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_r <= '0;
            last_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], pin};
            last_r <= sync_r[STAGES-1];
            rise_r <= sync_r[STAGES-1] & ~last_r;
            fall_r <= ~sync_r[STAGES-1] & last_r;
        end
    end

    assign level = last_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S receiver: oversamples codec sclk/lrclk/din, deserializes left/right
// words and holds one stereo pair for the SoC behind a valid/ready handshake.
module i2s_rx_capture
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic              din,
    output logic [DATA_W-1:0] left_sample,
    output logic [DATA_W-1:0] right_sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              frame_err,
    input  logic              clear_flags
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic              bit_evt_s;
    logic              lr_s;
    logic              d_s;
    logic [5:0]        sync_unused_s;

    i2s_state_e        state_r, state_s;
    logic [CNT_W-1:0]  count_r, count_s, count_in_s;
    logic [DATA_W-1:0] shift_r, shift_s, shift_in_s, word_s;
    logic              prev_lr_r, prev_lr_s;
    logic [DATA_W-1:0] left_stage_r, left_stage_s;
    logic [DATA_W-1:0] left_r, left_s, right_r, right_s;
    logic              valid_r, valid_s, overrun_r, overrun_s, ferr_r, ferr_s;
    logic              boundary_s, short_s, publish_s, set_ferr_s, set_ovr_s, accept_s;

    // Left-justify a partially filled word; missing LSBs become zero.
    function automatic logic [DATA_W-1:0] left_justify(input logic [DATA_W-1:0] word,
                                                       input logic [CNT_W-1:0]  n);
        logic [CNT_W-1:0] gap;
        gap = CNT_FULL - n;
        return word << gap;
    endfunction

    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .Clk(Clk), .Reset(Reset), .pin(sclk),
        .level(sync_unused_s[0]), .rise(bit_evt_s), .fall(sync_unused_s[1])
    );
    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
        .Clk(Clk), .Reset(Reset), .pin(lrclk),
        .level(lr_s), .rise(sync_unused_s[2]), .fall(sync_unused_s[3])
    );
    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_din_sync (
        .Clk(Clk), .Reset(Reset), .pin(din),
        .level(d_s), .rise(sync_unused_s[4]), .fall(sync_unused_s[5])
    );

    // state, shifter, staging, holding registers and sticky flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= IDLE;
            count_r      <= '0;
            shift_r      <= '0;
            prev_lr_r    <= 1'b0;
            left_stage_r <= '0;
            left_r       <= '0;
            right_r      <= '0;
            valid_r      <= 1'b0;
            overrun_r    <= 1'b0;
            ferr_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            shift_r      <= shift_s;
            prev_lr_r    <= prev_lr_s;
            left_stage_r <= left_stage_s;
            left_r       <= left_s;
            right_r      <= right_s;
            valid_r      <= valid_s;
            overrun_r    <= overrun_s;
            ferr_r       <= ferr_s;
        end
    end

    // slot sequencing: the boundary bit still belongs to the ending slot
    always_comb begin
        if (count_r < CNT_FULL) begin
            shift_in_s = {shift_r[DATA_W-2:0], d_s};
            count_in_s = count_r + CNT_W'(1);
        end else begin
            shift_in_s = shift_r;
            count_in_s = count_r;
        end
        word_s     = left_justify(shift_in_s, count_in_s);
        short_s    = (count_in_s < CNT_FULL);
        boundary_s = bit_evt_s && (lr_s != prev_lr_r);

        state_s      = state_r;
        count_s      = count_r;
        shift_s      = shift_r;
        left_stage_s = left_stage_r;
        left_s       = left_r;
        right_s      = right_r;
        publish_s    = 1'b0;
        set_ferr_s   = 1'b0;
        prev_lr_s    = bit_evt_s ? lr_s : prev_lr_r;

        case (state_r)
            IDLE: begin
                if (boundary_s && (lr_s == 1'b0)) begin
                    state_s = SHIFT_L;
                    count_s = '0;
                    shift_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT_L: begin
                if (boundary_s && (lr_s == 1'b1)) begin
                    left_stage_s = word_s;
                    set_ferr_s   = short_s;
                    state_s      = SHIFT_R;
                    count_s      = '0;
                    shift_s      = '0;
                end else if (boundary_s) begin
                    state_s    = IDLE;
                    set_ferr_s = 1'b1;
                end else if (bit_evt_s) begin
                    shift_s = shift_in_s;
                    count_s = count_in_s;
                end else begin
                    state_s = SHIFT_L;
                end
            end
            SHIFT_R: begin
                if (boundary_s && (lr_s == 1'b0)) begin
                    left_s     = left_stage_r;
                    right_s    = word_s;
                    publish_s  = 1'b1;
                    set_ferr_s = short_s;
                    state_s    = SHIFT_L;
                    count_s    = '0;
                    shift_s    = '0;
                end else if (boundary_s) begin
                    state_s    = IDLE;
                    set_ferr_s = 1'b1;
                end else if (bit_evt_s) begin
                    shift_s = shift_in_s;
                    count_s = count_in_s;
                end else begin
                    state_s = SHIFT_R;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // handshake and sticky flags; a set event beats a same-cycle clear
    always_comb begin
        accept_s  = valid_r & sample_ready;
        set_ovr_s = publish_s & valid_r & ~sample_ready;
        if (publish_s) begin
            valid_s = 1'b1;
        end else if (accept_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
        overrun_s = set_ovr_s  | (overrun_r & ~clear_flags);
        ferr_s    = set_ferr_s | (ferr_r & ~clear_flags);
    end

    assign left_sample  = left_r;
    assign right_sample = right_r;
    assign sample_valid = valid_r;
    assign overrun      = overrun_r;
    assign frame_err    = ferr_r;

endmodule
